// File: rtl/clint_bus_arbiter.sv
// rtl/clint_bus_arbiter.sv - two-master round-robin arbiter in front of the CLINT slave port
//
// Purpose:
//   Shares the single CLINT register port (msip / mtimecmp / mtime) between
//   m0 (hart data port) and m1 (debug/DMA port). Only one transaction is in
//   flight at a time. Arbitration happens only in IDLE and is round-robin.
//   A granted access drives s_cs for one ACCESS cycle plus WAIT_CYCLES
//   cycles, captures s_ddata in the last chip-select cycle, then pulses the
//   winner's ack for one cycle.
//
// Optional feature macro: CLINT_ARB_ADDR_CHECK_EN
//   When defined, m0_err/m1_err are added and a granted request whose
//   address is not one of the three register bases is answered locally
//   (ack=1, rdata=0, err=1) without touching the slave.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   mX_req                   request, held with fields stable until mX_ack
//   mX_addr/wdata/rw/word    access fields, forwarded unchanged to s_*
//   mX_ack                   one-cycle completion pulse
//   mX_rdata                 captured read data, valid while mX_ack=1
//   mX_err                   (macro only) unmapped-address response flag
//   s_cs                     CLINT chip select
//   s_addr/wdata/rw/word     latched fields of the granted request
//   s_ddata                  CLINT read data (undriven by slave when s_cs=0)

module clint_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES   = 1,
  parameter logic [15:0] MSIP_BASE     = 16'h0000,
  parameter logic [15:0] MTIMECMP_BASE = 16'h4000,
  parameter logic [15:0] MTIME_BASE    = 16'hbff8
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req,
  input  logic [15:0] m0_addr,
  input  logic [63:0] m0_wdata,
  input  logic        m0_rw,
  input  logic [1:0]  m0_word,
  output logic        m0_ack,
  output logic [63:0] m0_rdata,

  input  logic        m1_req,
  input  logic [15:0] m1_addr,
  input  logic [63:0] m1_wdata,
  input  logic        m1_rw,
  input  logic [1:0]  m1_word,
  output logic        m1_ack,
  output logic [63:0] m1_rdata,

  output logic        s_cs,
  output logic [15:0] s_addr,
  output logic [63:0] s_wdata,
  output logic        s_rw,
  output logic [1:0]  s_word,
`ifdef CLINT_ARB_ADDR_CHECK_EN
  output logic        m0_err,
  output logic        m1_err,
`endif
  input  logic [63:0] s_ddata
);

  // Elaboration-time sanity: the counter is 4 bits wide and the address
  // decode needs three distinct bases.
  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("clint_bus_arbiter: WAIT_CYCLES must be within 1..15");
    end
    if (MSIP_BASE == MTIMECMP_BASE || MSIP_BASE == MTIME_BASE ||
        MTIMECMP_BASE == MTIME_BASE) begin : g_bad_base
      $error("clint_bus_arbiter: register bases must be distinct");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic        r_gnt;         // id of the master owning the current transaction
  logic        r_last_grant;  // id of the most recent winner (for round-robin)
  logic [3:0]  r_wait_cnt;

  // Arbitration: a lone requester always wins; on a tie the master that did
  // not win last time is chosen, which makes grants alternate under load.
  logic        w_any_req;
  logic        w_gnt_id;
  logic [15:0] w_addr;
  logic [63:0] w_wdata;
  logic        w_rw;
  logic [1:0]  w_word;

  always_comb begin
    w_any_req = m0_req | m1_req;
    w_gnt_id  = (m0_req && m1_req) ? ~r_last_grant : m1_req;
    w_addr    = w_gnt_id ? m1_addr  : m0_addr;
    w_wdata   = w_gnt_id ? m1_wdata : m0_wdata;
    w_rw      = w_gnt_id ? m1_rw    : m0_rw;
    w_word    = w_gnt_id ? m1_word  : m0_word;
  end

`ifdef CLINT_ARB_ADDR_CHECK_EN
  logic w_addr_ok;
  always_comb begin
    w_addr_ok = (w_addr == MSIP_BASE) || (w_addr == MTIMECMP_BASE) ||
                (w_addr == MTIME_BASE);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_gnt        <= 1'b0;
      r_last_grant <= 1'b1;
      r_wait_cnt   <= 4'd0;
      s_cs         <= 1'b0;
      s_addr       <= 16'h0000;
      s_wdata      <= 64'h0;
      s_rw         <= 1'b0;
      s_word       <= 2'b00;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rdata     <= 64'h0;
      m1_rdata     <= 64'h0;
`ifdef CLINT_ARB_ADDR_CHECK_EN
      m0_err       <= 1'b0;
      m1_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_gnt        <= w_gnt_id;
            r_last_grant <= w_gnt_id;
            s_addr       <= w_addr;
            s_wdata      <= w_wdata;
            s_rw         <= w_rw;
            s_word       <= w_word;
`ifdef CLINT_ARB_ADDR_CHECK_EN
            // Unmapped offset: answer locally, slave never sees a chip select.
            if (!w_addr_ok) begin
              r_state <= ST_RESP;
              if (w_gnt_id) begin
                m1_ack   <= 1'b1;
                m1_rdata <= 64'h0;
                m1_err   <= 1'b1;
              end else begin
                m0_ack   <= 1'b1;
                m0_rdata <= 64'h0;
                m0_err   <= 1'b1;
              end
            end else
`endif
            begin
              s_cs    <= 1'b1;
              r_state <= ST_ACCESS;
            end
          end
        end

        ST_ACCESS: begin
          // The slave registers ddata at the end of this cycle; hold cs for
          // WAIT_CYCLES more cycles before sampling.
          r_wait_cnt <= WAIT_LOAD;
          r_state    <= ST_WAIT;
        end

        ST_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            // Last chip-select cycle: capture data and raise the ack register
            // so the pulse appears in the RESP cycle together with rdata.
            s_cs    <= 1'b0;
            r_state <= ST_RESP;
            if (r_gnt) begin
              m1_rdata <= s_ddata;
              m1_ack   <= 1'b1;
            end else begin
              m0_rdata <= s_ddata;
              m0_ack   <= 1'b1;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end

        ST_RESP: begin
          m0_ack  <= 1'b0;
          m1_ack  <= 1'b0;
`ifdef CLINT_ARB_ADDR_CHECK_EN
          m0_err  <= 1'b0;
          m1_err  <= 1'b0;
`endif
          r_state <= ST_IDLE;
        end

        default: begin
          s_cs    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clint_bus_arbiter.sv
// tb/tb_clint_bus_arbiter.sv - self-checking bench for clint_bus_arbiter
module tb_clint_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [15:0] m0_addr = '0, m1_addr = '0;
  logic [63:0] m0_wdata = '0, m1_wdata = '0;
  logic        m0_rw = 1'b0, m1_rw = 1'b0;
  logic [1:0]  m0_word = '0, m1_word = '0;
  logic [63:0] s_ddata = '0;

  // DUT a: WAIT_CYCLES=1
  logic        a_m0_ack, a_m1_ack, a_s_cs, a_s_rw;
  logic [63:0] a_m0_rdata, a_m1_rdata, a_s_wdata;
  logic [15:0] a_s_addr;
  logic [1:0]  a_s_word;
  // DUT b: WAIT_CYCLES=3
  logic        b_m0_ack, b_m1_ack, b_s_cs, b_s_rw;
  logic [63:0] b_m0_rdata, b_m1_rdata, b_s_wdata;
  logic [15:0] b_s_addr;
  logic [1:0]  b_s_word;

  clint_bus_arbiter #(.WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rw(m0_rw),
    .m0_word(m0_word), .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rw(m1_rw),
    .m1_word(m1_word), .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
    .s_cs(a_s_cs), .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_rw(a_s_rw),
    .s_word(a_s_word), .s_ddata(s_ddata)
  );

  clint_bus_arbiter #(.WAIT_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rw(m0_rw),
    .m0_word(m0_word), .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rw(m1_rw),
    .m1_word(m1_word), .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .s_cs(b_s_cs), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_rw(b_s_rw),
    .s_word(b_s_word), .s_ddata(s_ddata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv(input bit m, input logic req, input logic [15:0] addr,
                     input logic [63:0] wd, input logic rw, input logic [1:0] wo);
    if (!m) begin
      m0_req = req; m0_addr = addr; m0_wdata = wd; m0_rw = rw; m0_word = wo;
    end else begin
      m1_req = req; m1_addr = addr; m1_wdata = wd; m1_rw = rw; m1_word = wo;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic ack_a(input bit m);
    return m ? a_m1_ack : a_m0_ack;
  endfunction

  function automatic logic [63:0] rdata_a(input bit m);
    return m ? a_m1_rdata : a_m0_rdata;
  endfunction

  typedef struct {
    bit          mst;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic        rw;
    logic [1:0]  word;
    logic [63:0] ddata;
    bit          drop;       // release req right after grant
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int got[$];
    int tim[$];
    int cyc;
    logic any_ack;

    vecs[0] = '{1'b0, 16'hbff8, 64'h0,                   1'b1, 2'b11, 64'h1234,                1'b0, 64'h1234};
    vecs[1] = '{1'b1, 16'h4000, 64'hdeadbeef_cafef00d,   1'b0, 2'b11, 64'h0,                   1'b0, 64'h0};
    vecs[2] = '{1'b0, 16'h0000, 64'h1,                   1'b0, 2'b10, 64'hffffffff_ffffffff,   1'b0, 64'hffffffff_ffffffff};
    vecs[3] = '{1'b1, 16'h0004, 64'h0,                   1'b1, 2'b00, 64'ha5a5a5a5_5a5a5a5a,   1'b1, 64'ha5a5a5a5_5a5a5a5a};
    vecs[4] = '{1'b1, 16'hbffc, 64'h0123456789abcdef,    1'b1, 2'b01, 64'h80000000_00000001,   1'b0, 64'h80000000_00000001};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_a_cs", a_s_cs, 0);
    chk("rst_a_fields", {a_s_addr, a_s_rw, a_s_word}, 0);
    chk("rst_a_wdata", a_s_wdata, 0);
    chk("rst_a_acks", {a_m0_ack, a_m1_ack}, 0);
    chk("rst_a_rdata0", a_m0_rdata, 0);
    chk("rst_a_rdata1", a_m1_rdata, 0);
    chk("rst_b_cs", b_s_cs, 0);
    rst = 1'b1;
    @(negedge clk);

    // Tie right after reset: m0 first, IDLE cycle, then m1
    drv(0, 1, 16'hbff8, 64'h11, 1, 2'b11);
    drv(1, 1, 16'h4000, 64'h22, 0, 2'b11);
    s_ddata = 64'h77;
    @(negedge clk);
    chk("tie_T1_cs", a_s_cs, 1);
    chk("tie_T1_addr_m0", a_s_addr, 16'hbff8);
    @(negedge clk);
    chk("tie_T2_cs", a_s_cs, 1);
    @(negedge clk);
    chk("tie_T3_acks", {a_m0_ack, a_m1_ack}, 2'b10);
    chk("tie_T3_rdata", a_m0_rdata, 64'h77);
    m0_req = 1'b0;
    @(negedge clk);
    chk("tie_T4_idle_cs", a_s_cs, 0);
    @(negedge clk);
    chk("tie_T5_cs", a_s_cs, 1);
    chk("tie_T5_addr_m1", a_s_addr, 16'h4000);
    @(negedge clk);
    @(negedge clk);
    chk("tie_T7_acks", {a_m0_ack, a_m1_ack}, 2'b01);
    m1_req = 1'b0;

    // Continuous requests from both: strict alternation, 4-cycle period
    @(negedge clk);
    drv(0, 1, 16'h0000, 64'h0, 1, 2'b10);
    drv(1, 1, 16'hbff8, 64'h0, 1, 2'b11);
    cyc = 0;
    while (got.size() < 6 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (a_m0_ack) begin got.push_back(0); tim.push_back(cyc); end
      if (a_m1_ack) begin got.push_back(1); tim.push_back(cyc); end
    end
    chk("alt_count", got.size(), 6);
    for (int i = 0; i < got.size() && i < 6; i++) chk($sformatf("alt_order_%0d", i), got[i], i % 2);
    for (int i = 1; i < tim.size(); i++) chk($sformatf("alt_gap_%0d", i), tim[i] - tim[i-1], 4);
    idle(12);

    // Table of single-master transactions on WAIT_CYCLES=1
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_ddata = vecs[i].ddata;
      drv(vecs[i].mst, 1, vecs[i].addr, vecs[i].wdata, vecs[i].rw, vecs[i].word);
      @(negedge clk);
      chk($sformatf("v%0d_T1_cs", i), a_s_cs, 1);
      chk($sformatf("v%0d_s_addr", i), a_s_addr, vecs[i].addr);
      chk($sformatf("v%0d_s_wdata", i), a_s_wdata, vecs[i].wdata);
      chk($sformatf("v%0d_s_rw_word", i), {a_s_rw, a_s_word}, {vecs[i].rw, vecs[i].word});
      if (vecs[i].drop) drv(vecs[i].mst, 0, vecs[i].addr, vecs[i].wdata, vecs[i].rw, vecs[i].word);
      @(negedge clk);
      chk($sformatf("v%0d_T2_cs_ack", i), {a_s_cs, ack_a(vecs[i].mst)}, 2'b10);
      @(negedge clk);
      chk($sformatf("v%0d_T3_ack", i), ack_a(vecs[i].mst), 1);
      chk($sformatf("v%0d_T3_other_ack", i), ack_a(!vecs[i].mst), 0);
      chk($sformatf("v%0d_T3_cs", i), a_s_cs, 0);
      chk($sformatf("v%0d_rdata", i), rdata_a(vecs[i].mst), vecs[i].exp_rdata);
      drv(vecs[i].mst, 0, vecs[i].addr, vecs[i].wdata, vecs[i].rw, vecs[i].word);
      @(negedge clk);
      chk($sformatf("v%0d_T4_ack_low", i), ack_a(vecs[i].mst), 0);
    end

    // Single requester back-to-back: one transaction every 4 cycles
    idle(4);
    got.delete();
    tim.delete();
    drv(0, 1, 16'h4000, 64'h5, 0, 2'b11);
    cyc = 0;
    while (got.size() < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (a_m0_ack) begin got.push_back(0); tim.push_back(cyc); end
    end
    chk("b2b_count", got.size(), 3);
    for (int i = 1; i < tim.size(); i++) chk($sformatf("b2b_gap_%0d", i), tim[i] - tim[i-1], 4);
    idle(12);

    // WAIT_CYCLES=3: cs high 4 cycles, data sampled in last cs cycle
    @(negedge clk);
    s_ddata = 64'haaaa;
    drv(1, 1, 16'h4000, 64'h0, 0, 2'b11);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("w3_T%0d_cs", k), b_s_cs, 1);
      chk($sformatf("w3_T%0d_ack", k), b_m1_ack, 0);
      if (k == 4) s_ddata = 64'hbbbb;
    end
    @(negedge clk);
    chk("w3_T5_ack", b_m1_ack, 1);
    chk("w3_T5_cs", b_s_cs, 0);
    chk("w3_T5_rdata", b_m1_rdata, 64'hbbbb);
    chk("w3_T5_m0_ack", b_m0_ack, 0);
    m1_req = 1'b0;
    idle(12);

    // Reset during WAIT: cs drops at once, no ack, then tie goes to m0
    @(negedge clk);
    s_ddata = 64'h99;
    drv(0, 1, 16'h0000, 64'h0, 0, 2'b11);
    @(negedge clk);
    @(negedge clk);
    chk("rw_pre_cs", a_s_cs, 1);
    #2 rst = 1'b0;
    #1;
    chk("rw_async_cs", a_s_cs, 0);
    chk("rw_rdata0", a_m0_rdata, 0);
    m0_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    any_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_ack = any_ack | a_m0_ack | a_m1_ack | a_s_cs;
    end
    chk("rw_no_ack", any_ack, 0);
    drv(0, 1, 16'hbff8, 64'h0, 1, 2'b11);
    drv(1, 1, 16'h0000, 64'h0, 1, 2'b11);
    @(negedge clk);
    chk("rw_tie_addr_m0", a_s_addr, 16'hbff8);
    @(negedge clk);
    @(negedge clk);
    chk("rw_tie_acks", {a_m0_ack, a_m1_ack}, 2'b10);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
